uart_receiver: RTL and testbench
================================

# uart_receiver

UART receive engine for the 50 MHz system clock, paired with the transmit-side baud generator. It uses a 16x oversample tick from the same 2-bit baud_rate select, samples rx_in at mid-bit, and assembles LSB-first frames of 1 start bit, DATA_BITS data bits, optional even parity and 1 stop bit. It reports each frame with a one-cycle strobe and error flags, and sits between the serial pin and the consumer logic.

## Interface
- DATA_BITS, 8, number of data bits per frame (5..8)
- clock  input  1  system clock, 50 MHz
- reset_n  input  1  reset, asynchronous, active-low
- baud_rate  input  2  00=2400, 01=4800, 10=9600, 11=19200; same encoding as the transmit side
- rx_in  input  1  serial line, asynchronous, idle high
- rx_data  output  DATA_BITS  last received data word, LSB = first bit received
- rx_done  output  1  one-clock strobe: frame complete, outputs updated
- frame_err  output  1  stop bit sampled 0 in last frame
- parity_err  output  1  parity mismatch in last frame; tied 0 when parity is compiled out
- rx_busy  output  1  high in any state except IDLE

## Operation
- Input sync: two-flop synchronizer on rx_in; both flops reset to 1. All logic below uses the synchronized bit rxs.
- Tick generator:
  - 11-bit free-running counter; divisor N = 1302 / 651 / 326 / 163 for select 00 / 01 / 10 / 11.
  - When counter >= N-1: tick = 1 for one clock, and the counter returns to 0. Otherwise the counter increments.
  - The >= compare bounds the counter after a baud_rate change.
- Oversample counter: os_cnt, 4 bits; cleared on every state entry; increments on each tick.
- Bit counter: bit_cnt counts data bits received.
- FSM states and transitions:
  - IDLE: on a tick with rxs = 0, go to START.
  - START: on the 8th tick (mid start bit), resample.
    - rxs = 0: go to DATA, clear bit_cnt.
    - rxs = 1: return to IDLE; no strobe, no flag change (glitch rejection).
  - DATA: every 16th tick, shift rxs into the MSB of the shift register (right shift, LSB-first).
    - After DATA_BITS samples, go to PARITY if parity is compiled in, else STOP.
  - PARITY: on the 16th tick, capture the parity bit.
  - STOP: on the 16th tick, sample the stop bit. In the same clock:
    - rx_data <= shift register
    - frame_err <= ~rxs
    - parity_err <= computed result
    - rx_done = 1
    - go to IDLE
- A frame with frame_err = 1 still updates rx_data.
- Flags and rx_data hold their values until the next rx_done.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets the next start edge be detected without a lost frame.
- baud_rate changes take effect immediately. Changing it while rx_busy = 1 corrupts the current frame; this is not flagged, and the consumer must change rates only while idle.

## Timing
- Reset values: rx_data = 0, rx_done = 0, frame_err = 0, parity_err = 0, rx_busy = 0; FSM in IDLE; counters 0.
- Reset is honoured mid-frame: the partial frame is discarded and no strobe is issued.
- Start detection latency: 2 clocks (sync) plus up to 1 tick.
- Start-detect tick to rx_done: 8 + 16*DATA_BITS + 16 ticks, plus 16 more with parity.
  - Example, 9600 baud, 8 bits, no parity: 152 ticks = 49 552 clocks.
- rx_done is exactly one clock wide and is asserted in the cycle the outputs change.
- rx_busy rises one clock after the detecting tick and falls in the rx_done clock.
- Sample point: mid-bit, ±1 tick (1/16 bit) phase error from the free-running tick.

## Configuration
- UART_RX_PARITY_EN:
  - Defined: the PARITY state is included with even parity. parity_err = XOR of data bits XOR parity bit; its value is 1 on mismatch.
  - Undefined: no PARITY state; the frame is start + data + stop; parity_err is constant 0.

## Test plan
- 9600 baud, frame 0xA5 with a valid stop bit -> one rx_done pulse, rx_data = 0xA5, frame_err = 0, rx_busy low afterwards.
- 2400 baud, rx_in low for 3 ticks then high -> FSM returns to IDLE, no rx_done, flags and rx_data unchanged.
- 4800 baud, 0x3C sent with stop bit = 0 -> rx_done pulse, rx_data = 0x3C, frame_err = 1; next good frame 0x11 -> frame_err = 0.
- UART_RX_PARITY_EN defined, 9600 baud:
  - 0x01 with parity bit 1 -> parity_err = 0.
  - 0x01 with parity bit 0 -> parity_err = 1.
- 19200 baud, frames 0x00 then 0xFF back-to-back with one stop bit each -> two rx_done pulses, data 0x00 then 0xFF, no errors.
- reset_n asserted during data bit 4 of a frame -> all outputs 0, FSM in IDLE immediately; the following frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// UART receive engine. It runs on the 50 MHz system clock and uses a 16x
// oversample tick derived from the same 2-bit baud_rate select as the transmit
// side. It samples the synchronized serial line at mid-bit and assembles
// LSB-first frames: 1 start bit, DATA_BITS data bits, optional even parity and
// 1 stop bit. Each completed frame is reported with a one-clock rx_done strobe.
// The data word and the error flags hold until the next strobe.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : a PARITY state with even parity is included, and parity_err
//               reports a mismatch.
//   undefined : the frame is start + data + stop, and parity_err is tied 0.
//
// Parameters
//   DATA_BITS   data bits per frame, 5..8
//   DIV_2400    tick divisor for select 00 (default 1302 at 50 MHz)
//   DIV_4800    tick divisor for select 01 (default 651)
//   DIV_9600    tick divisor for select 10 (default 326)
//   DIV_19200   tick divisor for select 11 (default 163)
//   The divisors are parameters only so that a simulation can shorten bit
//   times. Synthesis uses the defaults.
//
// Ports
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   baud_rate   in   00=2400, 01=4800, 10=9600, 11=19200
//   rx_in       in   serial line, asynchronous, idle high
//   rx_data     out  last received data word, LSB = first bit received
//   rx_done     out  one-clock strobe: frame complete, outputs updated
//   frame_err   out  stop bit sampled 0 in the last frame
//   parity_err  out  parity mismatch in the last frame
//   rx_busy     out  high in any state except IDLE
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int DATA_BITS = 8,
    parameter int DIV_2400  = 1302,
    parameter int DIV_4800  = 651,
    parameter int DIV_9600  = 326,
    parameter int DIV_19200 = 163
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [1:0]           baud_rate,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);

    localparam int BIT_CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    // FSM encoding kept as plain constants for compatibility with older tools
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Oversample count at which the middle of the start bit is reached, and
    // the count that closes a full bit period.
    localparam logic [3:0] OS_MID  = 4'd7;
    localparam logic [3:0] OS_LAST = 4'd15;

    // -------------------------------------------------------------------------
    // Input synchronizer
    // -------------------------------------------------------------------------
    logic rx_meta;
    logic rxs;

    // NOTE: sequential state is assigned with non-blocking (<=) so that every
    // flop samples the values from before the edge. With blocking assignment,
    // rx_meta would pass straight through to rxs in a single clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // Both flops reset to the idle line level so that leaving reset
            // does not look like a start edge.
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rxs     <= rx_meta;
        end
    end

    // -------------------------------------------------------------------------
    // 16x tick generator
    // -------------------------------------------------------------------------
    logic [10:0] tick_cnt;
    logic [10:0] tick_limit;
    logic        tick;

    // NOTE: every variable written in always_comb gets a default before any
    // branch. A path that leaves it unassigned would infer a latch.
    always_comb begin
        tick_limit = 11'(DIV_2400 - 1);
        case (baud_rate)
            2'b00:   tick_limit = 11'(DIV_2400 - 1);
            2'b01:   tick_limit = 11'(DIV_4800 - 1);
            2'b10:   tick_limit = 11'(DIV_9600 - 1);
            default: tick_limit = 11'(DIV_19200 - 1);
        endcase
    end

    // The >= compare (rather than ==) bounds the counter when a rate change
    // leaves it above the new limit. Without it, the counter would run the
    // long way round through 2047.
    assign tick = (tick_cnt >= tick_limit);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 11'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Receive FSM and datapath
    // -------------------------------------------------------------------------
    logic [2:0]           state;
    logic [3:0]           os_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_err_next;

    // Even parity: the data bits plus the parity bit must XOR to 0.
    assign par_err_next = (^shift_reg) ^ par_bit;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_done <= 1'b0;

            if (tick) begin
                // os_cnt is a 4-bit counter, so it wraps from 15 to 0 by
                // itself at each bit boundary inside DATA. Only state entries
                // that interrupt the count need an explicit clear.
                os_cnt <= os_cnt + 4'd1;

                case (state)
                    S_IDLE: begin
                        if (!rxs) begin
                            state  <= S_START;
                            os_cnt <= '0;
                        end
                    end

                    S_START: begin
                        if (os_cnt == OS_MID) begin
                            os_cnt <= '0;
                            if (!rxs) begin
                                state   <= S_DATA;
                                bit_cnt <= '0;
                            end else begin
                                // The line went high again before mid-bit,
                                // so this was a glitch. Drop it silently.
                                state <= S_IDLE;
                            end
                        end
                    end

                    S_DATA: begin
                        if (os_cnt == OS_LAST) begin
                            // LSB-first: after DATA_BITS right shifts, the
                            // first bit received has reached bit 0.
                            shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (os_cnt == OS_LAST) begin
                            par_bit <= rxs;
                            state   <= S_STOP;
                        end
                    end
`endif

                    S_STOP: begin
                        // Returning to IDLE at mid-stop-bit leaves half a bit
                        // of margin for a back-to-back start edge.
                        if (os_cnt == OS_LAST) begin
                            rx_data    <= shift_reg;
                            frame_err  <= ~rxs;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_err_next;
`endif
                            rx_done    <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end

                    default: begin
                        state  <= S_IDLE;
                        os_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//
// Directed bench for uart_receiver. The DUT divisors are scaled down to
// 64/32/16/8 clocks per tick, which keeps the same 8:4:2:1 ratio between the
// four selects, so that whole frames fit in a short run. Each frame sent
// pushes its expected result to a queue. A monitor pops the queue and checks
// the result on every rx_done.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int DB = 8;

    logic          clock;
    logic          reset_n;
    logic [1:0]    baud_rate;
    logic          rx_in;
    logic [DB-1:0] rx_data;
    logic          rx_done;
    logic          frame_err;
    logic          parity_err;
    logic          rx_busy;

    uart_receiver #(
        .DATA_BITS (DB),
        .DIV_2400  (64),
        .DIV_4800  (32),
        .DIV_9600  (16),
        .DIV_19200 (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .baud_rate  (baud_rate),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          frame_err;
        logic          parity_err;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   tests      = 0;
    int   fails      = 0;
    int   done_count = 0;
    int   bit_clocks = 256;
    logic check_low_next = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int div_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return 64;
            2'b01:   return 32;
            2'b10:   return 16;
            default: return 8;
        endcase
    endfunction

    // Scoreboard monitor. The flag and data values are checked in the same
    // cycle as the strobe, and the strobe must be gone one clock later.
    always @(negedge clock) begin
        if (check_low_next) begin
            check_low_next = 1'b0;
            chk("done_width", rx_done, 1'b0);
        end
        if (reset_n && rx_done) begin
            check_low_next = 1'b1;
            done_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                last_exp = exp_q.pop_front();
                chk("rx_data",    rx_data,    last_exp.data);
                chk("frame_err",  frame_err,  last_exp.frame_err);
                chk("parity_err", parity_err, last_exp.parity_err);
                chk("busy_at_done", rx_busy,  1'b0);
            end
        end
    end

    task automatic set_baud(input logic [1:0] sel);
        baud_rate  = sel;
        bit_clocks = 16 * div_of(sel);
        repeat (2 * bit_clocks) @(posedge clock);
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (bit_clocks) @(posedge clock);
    endtask

    task automatic send_frame(input logic [DB-1:0] data, input logic stop_bit, input logic par_bit);
        exp_t e;
        e.data      = data;
        e.frame_err = ~stop_bit;
`ifdef UART_RX_PARITY_EN
        e.parity_err = (^data) ^ par_bit;
`else
        e.parity_err = 1'b0;
`endif
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`endif
        drive_bit(stop_bit);
        rx_in = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40000 && exp_q.size() != 0; i++) @(negedge clock);
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        logic [DB-1:0] abort_word;

        reset_n   = 1'b0;
        rx_in     = 1'b1;
        baud_rate = 2'b10;
        last_exp  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_rx_data",    rx_data,    0);
        chk("rst_rx_done",    rx_done,    0);
        chk("rst_frame_err",  frame_err,  0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_rx_busy",    rx_busy,    0);
        reset_n = 1'b1;

        // 9600: good frame 0xA5
        set_baud(2'b10);
        send_frame(8'hA5, 1'b1, ^8'hA5);
        wait_drain();
        repeat (bit_clocks) @(posedge clock);
        @(negedge clock);
        chk("a5_busy_after", rx_busy, 0);
        chk("a5_count", done_count, 1);

        // 2400: start glitch of 3 ticks must be rejected silently
        set_baud(2'b00);
        base  = done_count;
        rx_in = 1'b0;
        repeat (2 * div_of(2'b00)) @(posedge clock);
        @(negedge clock);
        chk("glitch_busy_during", rx_busy, 1);
        repeat (div_of(2'b00)) @(posedge clock);
        rx_in = 1'b1;
        repeat (16 * div_of(2'b00)) @(posedge clock);
        @(negedge clock);
        chk("glitch_busy_after", rx_busy,    0);
        chk("glitch_no_done",    done_count, base);
        chk("glitch_rx_data",    rx_data,    last_exp.data);
        chk("glitch_frame_err",  frame_err,  last_exp.frame_err);
        chk("glitch_parity_err", parity_err, last_exp.parity_err);

        // 4800: bad stop bit, then a good frame after the line idles
        set_baud(2'b01);
        base = done_count;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        repeat (2 * bit_clocks) @(posedge clock);
        send_frame(8'h11, 1'b1, ^8'h11);
        wait_drain();
        chk("ferr_count", done_count, base + 2);

`ifdef UART_RX_PARITY_EN
        // 9600 with parity: good and bad parity bit
        set_baud(2'b10);
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h01, 1'b1, 1'b0);
        wait_drain();
`endif

        // 19200: back-to-back 0x00 and 0xFF
        set_baud(2'b11);
        base = done_count;
        send_frame(8'h00, 1'b1, ^8'h00);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        wait_drain();
        chk("b2b_count", done_count, base + 2);

        // 9600: reset in the middle of data bit 4, then frame 0x5A
        set_baud(2'b10);
        base       = done_count;
        abort_word = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(abort_word[i]);
        rx_in = abort_word[4];
        repeat (bit_clocks / 2) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_rx_data",    rx_data,    0);
        chk("mid_rst_rx_done",    rx_done,    0);
        chk("mid_rst_frame_err",  frame_err,  0);
        chk("mid_rst_parity_err", parity_err, 0);
        chk("mid_rst_rx_busy",    rx_busy,    0);
        repeat (4) @(posedge clock);
        rx_in   = 1'b1;
        reset_n = 1'b1;
        repeat (2 * bit_clocks) @(posedge clock);
        chk("mid_rst_no_done", done_count, base);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        wait_drain();
        chk("post_rst_count", done_count, base + 1);

        repeat (bit_clocks) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
